// File: rtl/comp_n_seq.sv
// comp_n_seq -- iterative WIDTH-bit magnitude comparator.
//
// Compares A and B two bits (one digit) per clock, most-significant digit
// first, using a 16-entry x 3-bit lookup of the 2-bit digit compare. The
// scan stops on the first unequal digit, so latency is the position of
// that digit from the MSB (1..ND), or ND when the operands are equal.
//
// Parameters:
//   WIDTH   operand width in bits, even and >= 2 (ND = WIDTH/2 digits)
//
// Ports:
//   clock   rising-edge clock for all state
//   reset   synchronous, active-high reset
//   start   compare request, accepted only while busy=0
//   A, B    operands, sampled only on the accepting edge
//   A_gt_B  registered result A > B
//   A_lt_B  registered result A < B
//   A_eq_B  registered result A == B
//   busy    high while a compare is in progress
//   done    one-cycle pulse when a new result first becomes valid
//
// Build option:
//   COMP_N_SEQ_SIGNED_EN  when defined, operands are two's complement.
//                         The sign bit of both operands is inverted on the
//                         most-significant digit only, which maps signed
//                         ordering onto the unsigned digit lookup.

module comp_n_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             A_gt_B,
   output logic             A_lt_B,
   output logic             A_eq_B,
   output logic             busy,
   output logic             done
);

   localparam int unsigned ND    = WIDTH / 2;
   localparam int unsigned IDX_W = (ND > 1) ? $clog2(ND) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(ND - 1);

   // Digit compare table, indexed by {a_digit, b_digit}; entry = {gt, lt, eq}.
   localparam logic [2:0] LUT [16] = '{
      3'b001, 3'b010, 3'b010, 3'b010,   // a=0 vs b=0..3
      3'b100, 3'b001, 3'b010, 3'b010,   // a=1 vs b=0..3
      3'b100, 3'b100, 3'b001, 3'b010,   // a=2 vs b=0..3
      3'b100, 3'b100, 3'b100, 3'b001    // a=3 vs b=0..3
   };

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [IDX_W-1:0] idx;

   logic [1:0]       a_dig;
   logic [1:0]       b_dig;
   logic [2:0]       entry;

   always_comb begin
      a_dig = a_reg[{idx, 1'b0} +: 2];
      b_dig = b_reg[{idx, 1'b0} +: 2];
`ifdef COMP_N_SEQ_SIGNED_EN
      // Flipping both sign bits turns two's-complement order into unsigned order.
      if (idx == IDX_TOP) begin
         a_dig[1] = ~a_dig[1];
         b_dig[1] = ~b_dig[1];
      end
`endif
      entry = LUT[{a_dig, b_dig}];
   end

   assign busy = (state == SCAN);

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         idx    <= IDX_TOP;
         A_gt_B <= 1'b0;
         A_lt_B <= 1'b0;
         A_eq_B <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_reg <= A;
                  b_reg <= B;
                  idx   <= IDX_TOP;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (!entry[0]) begin
                  // First unequal digit decides the whole compare.
                  A_gt_B <= entry[2];
                  A_lt_B <= entry[1];
                  A_eq_B <= 1'b0;
                  done   <= 1'b1;
                  state  <= IDLE;
               end else if (idx == '0) begin
                  A_gt_B <= 1'b0;
                  A_lt_B <= 1'b0;
                  A_eq_B <= 1'b1;
                  done   <= 1'b1;
                  state  <= IDLE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comp_n_seq.sv
module tb_comp_n_seq;

   typedef struct {
      logic [2:0]  res;   // {gt, lt, eq}
      int unsigned lat;
      int unsigned acc;   // cycle count at the accepting edge
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       gt8, lt8, eq8, busy8, done8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       gt4, lt4, eq4, busy4, done4;

   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;

   exp_t sb8[$];
   exp_t sb4[$];

   comp_n_seq #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .A(a8), .B(b8),
      .A_gt_B(gt8), .A_lt_B(lt8), .A_eq_B(eq8), .busy(busy8), .done(done8)
   );

   comp_n_seq #(.WIDTH(4)) dut4 (
      .clock(clock), .reset(reset), .start(start4), .A(a4), .B(b4),
      .A_gt_B(gt4), .A_lt_B(lt4), .A_eq_B(eq4), .busy(busy4), .done(done4)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural reference: arithmetic compare plus first-unequal-digit latency.
   function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int va, vb, nd;
      nd = w / 2;
      va = int'(a);
      vb = int'(b);
`ifdef COMP_N_SEQ_SIGNED_EN
      if (a[w-1]) va = va - (1 << w);
      if (b[w-1]) vb = vb - (1 << w);
`endif
      e.res = (va > vb) ? 3'b100 : (va < vb) ? 3'b010 : 3'b001;
      e.lat = nd;
      for (int i = nd - 1; i >= 0; i--) begin
         if (a[2*i +: 2] != b[2*i +: 2]) begin
            e.lat = nd - i;
            break;
         end
      end
      e.acc = 0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one request at the current negedge; returns at the negedge after acceptance.
   task automatic start_8(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      a8 = a;
      b8 = b;
      start8 = 1'b1;
      e = model(8, a, b);
      e.acc = cyc + 1;
      sb8.push_back(e);
      @(negedge clock);
      start8 = 1'b0;
   endtask

   // Wait for done, then pop the scoreboard and compare result, latency, busy span.
   task automatic wait_8(input string tag);
      exp_t e;
      int n = 0;
      int busy_n = 0;
      while (!done8 && n < 20) begin
         if (busy8) busy_n++;
         @(negedge clock);
         n++;
      end
      chk({tag, " done_seen"}, 32'(done8), 32'd1);
      if (sb8.size() == 0) begin
         chk({tag, " sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb8.pop_front();
         chk({tag, " result"}, 32'({gt8, lt8, eq8}), 32'(e.res));
         chk({tag, " latency"}, cyc - e.acc, e.lat);
         chk({tag, " busy_cycles"}, 32'(busy_n), e.lat);
         chk({tag, " busy_at_done"}, 32'(busy8), 32'd0);
      end
   endtask

   initial begin
      exp_t e;
      int n;
      int pulses;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst8 outs", 32'({gt8, lt8, eq8, busy8, done8}), 32'd0);
      chk("rst4 outs", 32'({gt4, lt4, eq4, busy4, done4}), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle8 outs", 32'({gt8, lt8, eq8, busy8, done8}), 32'd0);

      // Equal operands: full ND-cycle scan
      start_8(8'h5A, 8'h5A);
      wait_8("eq_5A");
      @(negedge clock);
      chk("done_one_cycle", 32'(done8), 32'd0);
      chk("result_held", 32'({gt8, lt8, eq8}), 32'b001);

      // MSB digit decides (unsigned gt / signed lt)
      start_8(8'h80, 8'h7F);
      wait_8("msb_80_7F");

      // Last digit decides
      start_8(8'h34, 8'h37);
      wait_8("lsd_34_37");

      start_8(8'h1C, 8'h1F);
      wait_8("mid_1C_1F");

      start_8(8'hFF, 8'h00);
      wait_8("ff_00");

      // Start held high: second compare accepted in the done cycle
      a8 = 8'hC0;
      b8 = 8'h40;
      start8 = 1'b1;
      e = model(8, 8'hC0, 8'h40);
      e.acc = cyc + 1;
      sb8.push_back(e);
      @(negedge clock);
      wait_8("b2b_first");
      e = model(8, 8'hC0, 8'h40);
      e.acc = cyc + 1;
      sb8.push_back(e);
      @(negedge clock);
      start8 = 1'b0;
      chk("b2b accepted busy", 32'(busy8), 32'd1);
      chk("b2b done cleared", 32'(done8), 32'd0);
      wait_8("b2b_second");

      // Mid-SCAN operand change and start request are ignored
      start_8(8'h33, 8'h33);
      a8 = 8'h00;
      start8 = 1'b1;
      wait_8("midscan_ignore");
      start8 = 1'b0;
      @(negedge clock);
      chk("no_reaccept busy", 32'(busy8), 32'd0);

      // Reset on the 2nd SCAN cycle aborts with no done pulse
      start_8(8'h11, 8'h11);
      @(negedge clock);
      chk("pre_abort busy", 32'(busy8), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      void'(sb8.pop_back());
      chk("abort outs", 32'({gt8, lt8, eq8, busy8, done8}), 32'd0);
      pulses = 0;
      repeat (6) begin
         @(negedge clock);
         if (done8) pulses++;
      end
      chk("abort no_done", 32'(pulses), 32'd0);

      // Exhaustive WIDTH=4 sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            a4 = a[3:0];
            b4 = b[3:0];
            start4 = 1'b1;
            e = model(4, {4'h0, a4}, {4'h0, b4});
            e.acc = cyc + 1;
            sb4.push_back(e);
            @(negedge clock);
            start4 = 1'b0;
            n = 0;
            while (!done4 && n < 10) begin
               @(negedge clock);
               n++;
            end
            e = sb4.pop_front();
            chk($sformatf("w4 %0h/%0h done", a, b), 32'(done4), 32'd1);
            chk($sformatf("w4 %0h/%0h result", a, b), 32'({gt4, lt4, eq4}), 32'(e.res));
            chk($sformatf("w4 %0h/%0h latency", a, b), cyc - e.acc, e.lat);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
